// File: rtl/heater_pkg.sv
// Shared types and default sizing for the heater ramp sequencer.
// Imported by the PWM gate and the top-level FSM.
package heater_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  localparam int HEATER_GROUPS      = 16;
  localparam int HEATER_STEP_CYCLES = 1024;
  localparam int HEATER_PWM_W       = 8;

endpackage

// File: rtl/heater_pwm.sv
// Frame-latched PWM clock-enable for the heater array.
// Duty is sampled only at the frame boundary so a frame never glitches.
module heater_pwm
  import heater_pkg::*;
#(
  parameter int PWM_W = HEATER_PWM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [PWM_W-1:0] duty,
  output logic             ce
);

  localparam logic [PWM_W-1:0] TOP = '1;

  logic [PWM_W-1:0] pwm_cnt;
  logic [PWM_W-1:0] duty_q;

  // Free-running frame counter, frame-boundary duty latch, registered ce
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      duty_q  <= '0;
      ce      <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_cnt == TOP)
        duty_q <= duty;
      ce <= en & ((duty_q == TOP) | (pwm_cnt < duty_q));
    end
  end

endmodule

// File: rtl/heater_ramp_ctrl.sv
// Heater group sequencer: steps groups on/off one at a time
// so supply current ramps gradually, plus a PWM activity gate.
module heater_ramp_ctrl
  import heater_pkg::*;
#(
  parameter int GROUPS      = HEATER_GROUPS,
  parameter int STEP_CYCLES = HEATER_STEP_CYCLES,
  parameter int PWM_W       = HEATER_PWM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [PWM_W-1:0]  duty,
  output logic [GROUPS-1:0] grp_en,
  output logic              ce,
  output logic              busy,
  output logic [1:0]        state
);

  localparam int TW = $clog2(STEP_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(STEP_CYCLES - 1);
  localparam logic [GROUPS-1:0] ALL = '1;

  state_t            st;
  logic [TW-1:0]     tmr;
  logic [GROUPS-1:0] up_v;
  logic [GROUPS-1:0] dn_v;

  assign up_v  = {grp_en[GROUPS-2:0], 1'b1};
  assign dn_v  = grp_en >> 1;
  assign busy  = (st != IDLE);
  assign state = st;

  // Sequencer FSM with step timer and thermometer group shifter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= IDLE;
      grp_en <= '0;
      tmr    <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (start && !stop) begin
            st     <= RAMP_UP;
            grp_en <= up_v;
            tmr    <= '0;
          end
        end
        RAMP_UP: begin
          if (stop) begin
            grp_en <= dn_v;
            st     <= (dn_v == '0) ? IDLE : RAMP_DOWN;
            tmr    <= '0;
          end else if (tmr == TMAX) begin
            grp_en <= up_v;
            tmr    <= '0;
            if (up_v == ALL)
              st <= HOLD;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        HOLD: begin
          if (stop) begin
            grp_en <= dn_v;
            st     <= RAMP_DOWN;
            tmr    <= '0;
          end
        end
        RAMP_DOWN: begin
          if (start && !stop) begin
            grp_en <= up_v;
            st     <= (up_v == ALL) ? HOLD : RAMP_UP;
            tmr    <= '0;
          end else if (tmr == TMAX) begin
            grp_en <= dn_v;
            tmr    <= '0;
            if (dn_v == '0)
              st <= IDLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: begin
          st     <= IDLE;
          grp_en <= '0;
          tmr    <= '0;
        end
      endcase
    end
  end

  heater_pwm #(
    .PWM_W(PWM_W)
  ) u_pwm (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (busy),
    .duty (duty),
    .ce   (ce)
  );

endmodule

// File: tb/tb_heater_ramp_ctrl.sv
// Directed bench for heater_ramp_ctrl with GROUPS=4,
// STEP_CYCLES=8, PWM_W=4.
module tb_heater_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [3:0] duty;
  logic [3:0] grp_en;
  logic       ce;
  logic       busy;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  heater_ramp_ctrl #(
    .GROUPS(4),
    .STEP_CYCLES(8),
    .PWM_W(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .stop  (stop),
    .duty  (duty),
    .grp_en(grp_en),
    .ce    (ce),
    .busy  (busy),
    .state (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic s, input logic p);
    start = s;
    stop  = p;
    tick(1);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic count_ce(input int n, output int c);
    c = 0;
    repeat (n) begin
      tick(1);
      if (ce) c++;
    end
  endtask

  initial begin
    int  c;
    bit  found;
    logic prev;
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    duty  = 4'd0;
    #2;
    chk("rst_grp", grp_en, 0);
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ce", ce, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // full ramp-up
    pulse(1'b1, 1'b0);
    chk("up_g1", grp_en, 4'b0001);
    chk("up_st1", state, 1);
    chk("up_busy", busy, 1);
    tick(7);
    chk("up_g1_hold", grp_en, 4'b0001);
    tick(1);
    chk("up_g2", grp_en, 4'b0011);
    tick(8);
    chk("up_g3", grp_en, 4'b0111);
    chk("up_st3", state, 1);
    tick(8);
    chk("up_g4", grp_en, 4'b1111);
    chk("up_hold", state, 2);
    chk("duty0_ce", ce, 0);

    // start ignored in HOLD
    pulse(1'b1, 1'b0);
    chk("hold_start", state, 2);

    // PWM duty 5
    duty = 4'd5;
    tick(40);
    count_ce(16, c);
    chk("pwm5_win", c, 5);

    // mid-frame change 5 -> 12
    found = 1'b0;
    prev  = ce;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (ce && !prev) begin
        found = 1'b1;
        break;
      end
      prev = ce;
    end
    chk("pwm_frame_found", found, 1);
    duty = 4'd12;
    count_ce(15, c);
    chk("pwm_cur_frame", c + 1, 5);
    count_ce(16, c);
    chk("pwm_next_frame", c, 12);

    // duty all ones
    duty = 4'd15;
    tick(40);
    count_ce(16, c);
    chk("pwm15_win", c, 16);

    // full ramp-down
    pulse(1'b0, 1'b1);
    chk("dn_g3", grp_en, 4'b0111);
    chk("dn_st", state, 3);
    tick(8);
    chk("dn_g2", grp_en, 4'b0011);
    tick(8);
    chk("dn_g1", grp_en, 4'b0001);
    tick(7);
    chk("dn_g1_hold", grp_en, 4'b0001);
    tick(1);
    chk("dn_g0", grp_en, 4'b0000);
    chk("dn_idle", state, 0);
    chk("dn_busy", busy, 0);
    chk("ce_lag", ce, 1);
    tick(1);
    chk("ce_off", ce, 0);

    // reversal
    tick(3);
    pulse(1'b1, 1'b0);
    tick(8);
    chk("rev_g2", grp_en, 4'b0011);
    pulse(1'b0, 1'b1);
    chk("rev_dn", grp_en, 4'b0001);
    chk("rev_dn_st", state, 3);
    tick(2);
    pulse(1'b1, 1'b0);
    chk("rev_up", grp_en, 4'b0011);
    chk("rev_up_st", state, 1);
    tick(7);
    chk("rev_up_wait", grp_en, 4'b0011);
    tick(1);
    chk("rev_up_g3", grp_en, 4'b0111);

    // start+stop in RAMP_UP resolves to stop
    pulse(1'b1, 1'b1);
    chk("both_up_st", state, 3);
    chk("both_up_g", grp_en, 4'b0011);
    tick(16);
    chk("both_up_idle", state, 0);

    // start+stop in IDLE ignored
    pulse(1'b1, 1'b1);
    chk("both_idle_st", state, 0);
    chk("both_idle_g", grp_en, 0);

    // async reset mid ramp-up
    pulse(1'b1, 1'b0);
    tick(11);
    chk("ar_pre", grp_en, 4'b0011);
    chk("ar_pre_ce", ce, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_grp", grp_en, 0);
    chk("ar_state", state, 0);
    chk("ar_busy", busy, 0);
    chk("ar_ce", ce, 0);
    #2;
    rst_n = 1'b1;
    tick(2);
    pulse(1'b1, 1'b0);
    chk("ar_restart", grp_en, 4'b0001);
    chk("ar_restart_st", state, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
